// File: rtl/riscvibe_pkg.sv
// Shared encodings for the pipeline memory stage: funct3 codes, access sizes,
// FSM states and fault causes.
package riscvibe_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {MEM_IDLE, MEM_WAIT_RESP} mem_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

  localparam logic [1:0] FAULT_NONE        = 2'b00;
  localparam logic [1:0] FAULT_LD_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ST_MISALIGN = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT     = 2'b11;

  // Unknown funct3 codes fall back to a full-word access.
  function automatic mem_size_e access_size(input logic [2:0] f3, input logic is_store);
    access_size = SZ_W;
    if (is_store) begin
      case (f3)
        F3_SB:   access_size = SZ_B;
        F3_SH:   access_size = SZ_H;
        default: access_size = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: access_size = SZ_B;
        F3_LH, F3_LHU: access_size = SZ_H;
        default:       access_size = SZ_W;
      endcase
    end
  endfunction

endpackage

// File: rtl/mem_data_align.sv
// Store lane replication / byte enables and load lane extraction / extension.
module mem_data_align
  import riscvibe_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_shift = ld_word_i >> {offset_i, 3'b000};
  assign ld_byte  = ld_shift[7:0];
  assign ld_half  = offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

  always_comb begin
    st_wdata_o = st_data_i;
    st_be_o    = 4'b1111;
    ld_data_o  = ld_word_i;
    case (size_i)
      SZ_B: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_be_o    = 4'b0001 << offset_i;
        ld_data_o  = unsigned_i ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_H: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_be_o    = 4'b0011 << {offset_i[1], 1'b0};
        ld_data_o  = unsigned_i ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        st_wdata_o = st_data_i;
        st_be_o    = 4'b1111;
        ld_data_o  = ld_word_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory handshake, stall generation, response
// timeout and the MEM/WB register.
//   state         | meaning
//   MEM_IDLE      | no load outstanding; requests issued combinationally
//   MEM_WAIT_RESP | load accepted, waiting for response or timeout
module mem_stage
  import riscvibe_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_mem_valid,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic [XLEN-1:0] ex_mem_rs2_data,
  input  logic [4:0]      ex_mem_rd_addr,
  input  logic            ex_mem_reg_write,
  input  logic            ex_mem_mem_read,
  input  logic            ex_mem_mem_write,
  input  logic [2:0]      ex_mem_funct3,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [3:0]      dmem_req_be,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_rdata,
  output logic            mem_stall,
  output logic            mem_wb_valid,
  output logic [4:0]      mem_wb_rd_addr,
  output logic            mem_wb_reg_write,
  output logic [XLEN-1:0] mem_wb_wdata,
  output logic            mem_wb_fault,
  output logic [1:0]      mem_wb_fault_cause
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_size_e        size;
  logic             access, misalign, fault;
  logic [1:0]       cause;
  logic [XLEN-1:0]  ld_data;

  assign access   = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
  assign size     = access_size(ex_mem_funct3, ex_mem_mem_write);
  assign misalign = access & (((size == SZ_H) & ex_mem_alu_result[0]) |
                              ((size == SZ_W) & (ex_mem_alu_result[1:0] != 2'b00)));

  assign dmem_req_valid = !rst & (state_q == MEM_IDLE) & access & !misalign;
  assign dmem_req_we    = ex_mem_mem_write;
  assign dmem_req_addr  = {ex_mem_alu_result[XLEN-1:2], 2'b00};

  mem_data_align u_align (
    .size_i     (size),
    .unsigned_i (ex_mem_funct3[2]),
    .offset_i   (ex_mem_alu_result[1:0]),
    .st_data_i  (ex_mem_rs2_data),
    .ld_word_i  (dmem_resp_rdata),
    .st_wdata_o (dmem_req_wdata),
    .st_be_o    (dmem_req_be),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    cause     = FAULT_NONE;
    if (!rst) begin
      case (state_q)
        MEM_IDLE: begin
          if (misalign) cause = ex_mem_mem_write ? FAULT_ST_MISALIGN : FAULT_LD_MISALIGN;
          if (dmem_req_valid) begin
            // An accepted store retires now; everything else holds the pipe.
            mem_stall = !(dmem_req_ready & ex_mem_mem_write);
            if (dmem_req_ready & ex_mem_mem_read) begin
              state_d = MEM_WAIT_RESP;
              cnt_d   = '0;
            end
          end
        end
        MEM_WAIT_RESP: begin
          if (dmem_resp_valid) begin
            state_d = MEM_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = MEM_IDLE;
            cnt_d   = '0;
            cause   = FAULT_TIMEOUT;
          end else begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = MEM_IDLE;
      endcase
    end
  end

  assign fault = (cause != FAULT_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= MEM_IDLE;
      cnt_q              <= '0;
      mem_wb_valid       <= 1'b0;
      mem_wb_rd_addr     <= '0;
      mem_wb_reg_write   <= 1'b0;
      mem_wb_wdata       <= '0;
      mem_wb_fault       <= 1'b0;
      mem_wb_fault_cause <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (mem_stall || !ex_mem_valid) begin
        mem_wb_valid       <= 1'b0;
        mem_wb_rd_addr     <= '0;
        mem_wb_reg_write   <= 1'b0;
        mem_wb_wdata       <= '0;
        mem_wb_fault       <= 1'b0;
        mem_wb_fault_cause <= FAULT_NONE;
      end else begin
        mem_wb_valid       <= 1'b1;
        mem_wb_rd_addr     <= ex_mem_rd_addr;
        mem_wb_reg_write   <= ex_mem_reg_write & !fault;
        mem_wb_wdata       <= (ex_mem_mem_read & !fault) ? ld_data : ex_mem_alu_result;
        mem_wb_fault       <= fault;
        mem_wb_fault_cause <= cause;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: bus/stall checks inline, MEM/WB results
// checked against a scoreboard of expected retirements.
module tb_mem_stage;

  logic        clk, rst;
  logic        ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
  logic [31:0] ex_mem_alu_result, ex_mem_rs2_data;
  logic [4:0]  ex_mem_rd_addr;
  logic [2:0]  ex_mem_funct3;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;
  logic        mem_stall, mem_wb_valid, mem_wb_reg_write, mem_wb_fault;
  logic [4:0]  mem_wb_rd_addr;
  logic [31:0] mem_wb_wdata;
  logic [1:0]  mem_wb_fault_cause;

  mem_stage #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_rs2_data(ex_mem_rs2_data), .ex_mem_rd_addr(ex_mem_rd_addr),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_funct3(ex_mem_funct3),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .mem_stall(mem_stall), .mem_wb_valid(mem_wb_valid),
    .mem_wb_rd_addr(mem_wb_rd_addr), .mem_wb_reg_write(mem_wb_reg_write),
    .mem_wb_wdata(mem_wb_wdata), .mem_wb_fault(mem_wb_fault),
    .mem_wb_fault_cause(mem_wb_fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] wdata;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic rw, input logic [31:0] wdata,
                          input logic fault, input logic [1:0] cause);
    exp_t x;
    x.rd = rd; x.rw = rw; x.wdata = wdata; x.fault = fault; x.cause = cause;
    sb_q.push_back(x);
  endtask

  task automatic set_op(input logic v, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                        input logic [2:0] f3);
    ex_mem_valid = v; ex_mem_alu_result = addr; ex_mem_rs2_data = rs2;
    ex_mem_rd_addr = rd; ex_mem_reg_write = rw; ex_mem_mem_read = mr;
    ex_mem_mem_write = mw; ex_mem_funct3 = f3;
  endtask

  // One clock: check stall at the falling edge, then advance past the rising edge.
  task automatic cyc(input string tag, input logic exp_stall);
    @(negedge clk);
    check(tag, mem_stall, exp_stall);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && mem_wb_valid) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected_valid", mem_wb_valid, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("wb_rd", mem_wb_rd_addr, e.rd);
        check("wb_reg_write", mem_wb_reg_write, e.rw);
        check("wb_fault", mem_wb_fault, e.fault);
        check("wb_cause", mem_wb_fault_cause, e.cause);
        if (!e.fault) check("wb_wdata", mem_wb_wdata, e.wdata);
      end
    end
  end

  initial begin
    rst = 1'b1;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_stall", mem_stall, 1'b0);
    check("rst_req_valid", dmem_req_valid, 1'b0);
    check("rst_wb_valid", mem_wb_valid, 1'b0);
    check("rst_wb_wdata", mem_wb_wdata, 32'h0);
    check("rst_wb_fault", mem_wb_fault, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SW 0xDEADBEEF -> 0x104, accepted immediately
    dmem_req_ready = 1'b1;
    set_op(1'b1, 32'h104, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
    push_exp(5'd0, 1'b0, 32'h104, 1'b0, 2'b00);
    @(negedge clk);
    check("sw_req_valid", dmem_req_valid, 1'b1);
    check("sw_we", dmem_req_we, 1'b1);
    check("sw_addr", dmem_req_addr, 32'h104);
    check("sw_be", dmem_req_be, 4'b1111);
    check("sw_wdata", dmem_req_wdata, 32'hDEADBEEF);
    check("sw_stall", mem_stall, 1'b0);
    @(posedge clk); #1;

    // LB x5 from 0x103: 2 cycles not ready, response 3 cycles after accept
    dmem_req_ready = 1'b0;
    set_op(1'b1, 32'h103, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000);
    push_exp(5'd5, 1'b1, 32'hFFFFFF80, 1'b0, 2'b00);
    @(negedge clk);
    check("lb_req_valid_held", dmem_req_valid, 1'b1);
    check("lb_addr", dmem_req_addr, 32'h100);
    check("lb_we", dmem_req_we, 1'b0);
    @(posedge clk); #1;
    cyc("lb_stall_nr2", 1'b1);
    dmem_req_ready = 1'b1;
    cyc("lb_stall_accept", 1'b1);
    dmem_req_ready = 1'b0;
    @(negedge clk);
    check("lb_wait_req_valid", dmem_req_valid, 1'b0);
    check("lb_bubble", mem_wb_valid, 1'b0);
    @(posedge clk); #1;
    cyc("lb_stall_w2", 1'b1);
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h80FF1234;
    cyc("lb_resp", 1'b0);
    dmem_resp_valid = 1'b0;

    // LHU x7 from 0x102
    dmem_req_ready = 1'b1;
    set_op(1'b1, 32'h102, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b101);
    push_exp(5'd7, 1'b1, 32'h0000BEEF, 1'b0, 2'b00);
    cyc("lhu_accept", 1'b1);
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'hBEEF0000;
    cyc("lhu_resp", 1'b0);
    dmem_resp_valid = 1'b0;

    // SH 0x1234 -> 0x102
    set_op(1'b1, 32'h102, 32'hABCD1234, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001);
    push_exp(5'd0, 1'b0, 32'h102, 1'b0, 2'b00);
    @(negedge clk);
    check("sh_wdata", dmem_req_wdata, 32'h12341234);
    check("sh_be", dmem_req_be, 4'b1100);
    check("sh_addr", dmem_req_addr, 32'h100);
    @(posedge clk); #1;

    // SB 0xA5 -> 0x101
    set_op(1'b1, 32'h101, 32'h000000A5, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000);
    push_exp(5'd0, 1'b0, 32'h101, 1'b0, 2'b00);
    @(negedge clk);
    check("sb_wdata", dmem_req_wdata, 32'hA5A5A5A5);
    check("sb_be", dmem_req_be, 4'b0010);
    @(posedge clk); #1;

    // LW x9 from 0x101: misaligned load
    set_op(1'b1, 32'h101, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010);
    push_exp(5'd9, 1'b0, 32'h0, 1'b1, 2'b01);
    @(negedge clk);
    check("lw_mis_req_valid", dmem_req_valid, 1'b0);
    @(posedge clk); #1;

    // SH to 0x103: misaligned store
    set_op(1'b1, 32'h103, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001);
    push_exp(5'd0, 1'b0, 32'h0, 1'b1, 2'b10);
    cyc("sh_mis_stall", 1'b0);

    // LW x3 from 0x200 with no response: 8 stall cycles then timeout
    set_op(1'b1, 32'h200, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010);
    push_exp(5'd3, 1'b0, 32'h0, 1'b1, 2'b11);
    cyc("to_accept", 1'b1);
    dmem_req_ready = 1'b0;
    for (int i = 0; i < 7; i++) cyc("to_wait", 1'b1);
    cyc("to_expire", 1'b0);
    set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h12345678;
    @(negedge clk);
    check("late_resp_stall", mem_stall, 1'b0);
    check("late_resp_req", dmem_req_valid, 1'b0);
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    check("late_resp_wb", mem_wb_valid, 1'b0);
    @(posedge clk); #1;

    // Reset while waiting for a load response
    dmem_req_ready = 1'b1;
    set_op(1'b1, 32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010);
    cyc("rw_accept", 1'b1);
    cyc("rw_wait", 1'b1);
    rst = 1'b1;
    set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    check("rw_stall_in_rst", mem_stall, 1'b0);
    check("rw_req_in_rst", dmem_req_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rw_stall_after", mem_stall, 1'b0);
    check("rw_wb_valid", mem_wb_valid, 1'b0);
    check("rw_wb_rd", mem_wb_rd_addr, 5'd0);
    check("rw_wb_cause", mem_wb_fault_cause, 2'b00);
    @(posedge clk); #1;

    // LBU x6 from 0x103 proves the FSM restarted from idle
    set_op(1'b1, 32'h103, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b100);
    push_exp(5'd6, 1'b1, 32'h00000080, 1'b0, 2'b00);
    @(negedge clk);
    check("lbu_req_valid", dmem_req_valid, 1'b1);
    @(posedge clk); #1;
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h80FF1234;
    cyc("lbu_resp", 1'b0);
    dmem_resp_valid = 1'b0;
    set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (2) begin @(posedge clk); #1; end

    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
